reducer_noc: RTL and testbench
==============================

REDUCER_NOC -- requirements
Module: reducer_noc

Interface
REQ-001 SHALL have parameter DEPTH, default 10, giving the number of distinct key entries held.
REQ-002 SHALL have parameter CNT_W, default 32, giving the count field width (fixed at 32 in this revision).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port data_in, input, 32 bits: pair word from the router.
REQ-006 SHALL have port data_in_ready, input, 1 bit: data_in valid this cycle.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts a word this cycle.
REQ-008 SHALL have port flush, input, 1 bit: single-cycle request to emit and clear the table.
REQ-009 SHALL have port fifo_in_ready, input, 1 bit: downstream can take a word.
REQ-010 SHALL have port data_out, output, 32 bits: reduced pair word.
REQ-011 SHALL have port data_out_ready, output, 1 bit: data_out valid.
REQ-012 SHALL have port table_full, output, 1 bit: sticky flag, set when a new key is dropped.

Function
REQ-013 SHALL treat a pair as 128 bits: key = [127:32], count = [31:0]; the pair SHALL arrive as four words, [31:0] first and [127:96] last.
REQ-014 SHALL accept a word only on a cycle where data_in_ready and in_ready are both 1, filling the beat counter 0 to 3.
REQ-015 SHALL use states COLLECT, SEARCH, FLUSH; in_ready SHALL be 1 only in COLLECT.
REQ-016 SHALL move from COLLECT to SEARCH on the cycle after the fourth beat is accepted.
REQ-017 SHALL, in SEARCH, compare one entry per cycle, index 0 upward, against entries 0..used-1.
REQ-018 SHALL, on a match at index i, add the incoming count to entry i at the edge ending compare cycle i, then return to COLLECT.
REQ-019 SHALL, when no entry matches and used<DEPTH, write the pair to entry[used], increment used, and return to COLLECT one cycle after the last compare.
REQ-020 SHALL, when no entry matches and used==DEPTH, discard the pair, set table_full, and return to COLLECT.
REQ-021 SHALL, with used==0, skip comparison and allocate entry 0 in the first SEARCH cycle.
REQ-022 SHALL latch flush into flush_pending at any time.
REQ-023 SHALL enter FLUSH from COLLECT only when flush_pending is set and the beat counter is 0; a partially received pair SHALL complete its SEARCH first.
REQ-024 SHALL, in FLUSH, emit entries 0..used-1, four words each, [31:0] first.
REQ-025 SHALL advance FLUSH output one word per cycle only while fifo_in_ready is 1; data_out_ready SHALL be 1 exactly on those cycles.
REQ-026 SHALL keep data_out at 0 whenever data_out_ready is 0.
REQ-027 SHALL, after the last word is emitted, clear used, flush_pending and table_full, and return to COLLECT.
REQ-028 SHALL, with used==0 at flush, emit nothing and return to COLLECT after one cycle.

Reset
REQ-029 SHALL, on rst low, immediately clear all outputs to 0, state to COLLECT, beat counter, used, flush_pending and table_full, including mid-SEARCH or mid-FLUSH; entry contents need not be cleared.

Configuration
REQ-030 SHALL, with REDUCER_SAT_ADD_EN defined, saturate the count addition at 32'hFFFF_FFFF; without it, the addition SHALL wrap modulo 2^32.

Structure
REQ-031 SHALL place state encodings, pair field bounds (KEY_LSB=32, KEY_MSB=127) and the word count constant (4) in shared package noc_pkg.
REQ-032 SHALL implement word-to-pair assembly in one sub-module named pair_assembler; all other logic SHALL be in reducer_noc.

Verification
REQ-033 SHALL cover: pairs (key A, count 1), (key B, count 2), (key A, count 3), then flush with fifo_in_ready=1 -> 8 consecutive words: A with count 4, then B with count 2.
REQ-034 SHALL cover: DEPTH+1 distinct keys -> table_full=1 after the last SEARCH; flush emits DEPTH entries; table_full=0 afterwards.
REQ-035 SHALL cover: flush pulsed after beat 2 of a pair -> that pair is reduced before the first output word appears.
REQ-036 SHALL cover: fifo_in_ready toggled 1,0,1,0 during FLUSH -> data_out_ready follows it and no word is lost or repeated.
REQ-037 SHALL cover: count 32'hFFFF_FFFF plus 2 on the same key -> 32'hFFFF_FFFF with REDUCER_SAT_ADD_EN defined, 32'h1 without.
REQ-038 SHALL cover: rst asserted mid-FLUSH -> data_out_ready=0 and in_ready=1 after release; a subsequent flush emits nothing.

Source files
------------

// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Definitions shared by the reducer_noc block and its pair_assembler.
//   - Word and pair geometry. A pair is 128 bits: count in [31:0] and key in
//     [127:32]. It moves as four 32-bit words, low word first.
//   - The reducer FSM state encoding.
// -----------------------------------------------------------------------------
package noc_pkg;

  localparam int WORD_W         = 32;
  localparam int PAIR_W         = 128;
  localparam int KEY_LSB        = 32;
  localparam int KEY_MSB        = 127;
  localparam int KEY_W          = KEY_MSB - KEY_LSB + 1;
  localparam int WORDS_PER_PAIR = 4;
  localparam int BEAT_W         = $clog2(WORDS_PER_PAIR);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_PAIR - 1);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_SEARCH  = 2'd1,
    ST_FLUSH   = 2'd2
  } state_e;

endpackage

// File: rtl/pair_assembler.sv
// -----------------------------------------------------------------------------
// pair_assembler
// Collects four accepted 32-bit words into one 128-bit pair. The first word
// ends up in [31:0] and the last word in [127:96].
// Ports:
//   clk      - clock
//   rst_n    - asynchronous active-low reset. Clears the beat counter only.
//   word_i   - incoming word
//   accept_i - word_i is consumed on this cycle
//   beat_o   - number of words of the current pair already held (0..3)
//   pair_o   - assembled pair. Valid once the fourth word has been accepted.
// -----------------------------------------------------------------------------
module pair_assembler
  import noc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] word_i,
  input  logic              accept_i,
  output logic [BEAT_W-1:0] beat_o,
  output logic [PAIR_W-1:0] pair_o
);

  logic [BEAT_W-1:0] beat_q;
  logic [PAIR_W-1:0] pair_q;

  // NOTE: clocked state is always written with non-blocking (<=) so every
  // flop samples values from before the edge, whatever the block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
    end else if (accept_i) begin
      // The counter width matches the word count, so it wraps to 0 after
      // the last beat.
      beat_q <= beat_q + 1'b1;
    end
  end

  // NOTE: pure data storage has no reset. The control logic never uses
  // these bits before it has written them, and leaving the reset off keeps
  // the wide register off the reset tree.
  always_ff @(posedge clk) begin
    if (accept_i) begin
      // Shift right by one word. After four beats the first word is at [31:0].
      pair_q <= {word_i, pair_q[PAIR_W-1:WORD_W]};
    end
  end

  assign beat_o = beat_q;
  assign pair_o = pair_q;

endmodule

// File: rtl/reducer_noc.sv
// -----------------------------------------------------------------------------
// reducer_noc
// Key/count reducer. It accepts 128-bit pairs as four words. It looks each key
// up in a small table, one entry per cycle. On a match it adds the count to
// that entry. On a miss it allocates a new entry, or drops the pair and sets a
// sticky table_full flag when the table is full. A flush streams the table out
// four words per entry, low word first, under downstream flow control. It then
// clears the table.
//
// Build option: define REDUCER_SAT_ADD_EN to make count accumulation saturate
// at all-ones. When it is not defined, the sum wraps modulo 2^32.
//
// Ports:
//   clk            - clock, all state changes on the rising edge
//   rst            - asynchronous active-low reset
//   data_in        - pair word from the router
//   data_in_ready  - data_in is valid this cycle
//   in_ready       - block accepts a word this cycle (registered)
//   flush          - single-cycle request to emit and clear the table
//   fifo_in_ready  - downstream can take a word this cycle
//   data_out       - reduced pair word. Held at 0 when not valid.
//   data_out_ready - data_out is valid
//   table_full     - sticky. Set when a new key is dropped.
// -----------------------------------------------------------------------------
module reducer_noc
  import noc_pkg::*;
#(
  parameter int DEPTH = 10,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] data_in,
  input  logic              data_in_ready,
  output logic              in_ready,
  input  logic              flush,
  input  logic              fifo_in_ready,
  output logic [WORD_W-1:0] data_out,
  output logic              data_out_ready,
  output logic              table_full
);

  localparam int IDX_W = $clog2(DEPTH + 1);
  localparam logic [IDX_W-1:0] DEPTH_V = IDX_W'(DEPTH);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  used_q, used_d;
  logic [BEAT_W-1:0] word_q, word_d;
  logic              flush_pending_q, flush_pending_d;
  logic              table_full_q, table_full_d;
  logic              in_ready_q, in_ready_d;

  // The entry table has no reset. used_q decides which entries are live.
  logic [KEY_W-1:0]  key_q [DEPTH];
  logic [CNT_W-1:0]  cnt_q [DEPTH];

  logic              accept;
  logic [BEAT_W-1:0] beat, beat_nxt;
  logic [PAIR_W-1:0] pair;
  logic [KEY_W-1:0]  in_key;
  logic [CNT_W-1:0]  in_cnt;
  logic              hit;
  logic              alloc, add_en, search_end, flush_end, emit;
  logic [PAIR_W-1:0] entry_pair;

  function automatic logic [CNT_W-1:0] add_count(input logic [CNT_W-1:0] a,
                                                  input logic [CNT_W-1:0] b);
`ifdef REDUCER_SAT_ADD_EN
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
`else
    return a + b;
`endif
  endfunction

  assign accept = data_in_ready & in_ready_q;

  pair_assembler u_pair_assembler (
    .clk      (clk),
    .rst_n    (rst),
    .word_i   (data_in),
    .accept_i (accept),
    .beat_o   (beat),
    .pair_o   (pair)
  );

  assign in_key   = pair[KEY_MSB:KEY_LSB];
  assign in_cnt   = pair[CNT_W-1:0];
  assign beat_nxt = accept ? beat + 1'b1 : beat;
  assign hit      = (key_q[idx_q] == in_key);

  // NOTE: combinational blocks assign a default to every output first. An
  // output left unassigned on some path would infer a latch.
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    used_d          = used_q;
    word_d          = word_q;
    table_full_d    = table_full_q;
    flush_pending_d = flush_pending_q | flush;
    alloc           = 1'b0;
    add_en          = 1'b0;
    search_end      = 1'b0;
    flush_end       = 1'b0;
    emit            = 1'b0;

    case (state_q)
      ST_COLLECT: begin
        if (accept && beat == LAST_BEAT) begin
          state_d = ST_SEARCH;
          idx_d   = '0;
        end else if (flush_pending_q && beat == '0) begin
          // A flush waits on a pair boundary, so a partial pair is never lost.
          state_d = ST_FLUSH;
          idx_d   = '0;
          word_d  = '0;
        end
      end

      ST_SEARCH: begin
        search_end = 1'b1;
        if (used_q == '0) begin
          alloc = 1'b1;
        end else if (hit) begin
          add_en = 1'b1;
        end else if (idx_q != used_q - 1'b1) begin
          idx_d      = idx_q + 1'b1;
          search_end = 1'b0;
        end else if (used_q < DEPTH_V) begin
          alloc = 1'b1;
        end else begin
          table_full_d = 1'b1;
        end
        if (alloc) used_d = used_q + 1'b1;
        if (search_end) begin
          state_d = ST_COLLECT;
          idx_d   = '0;
        end
      end

      ST_FLUSH: begin
        if (used_q == '0) begin
          flush_end = 1'b1;
        end else if (fifo_in_ready) begin
          emit   = 1'b1;
          word_d = word_q + 1'b1;
          if (word_q == LAST_BEAT) begin
            if (idx_q == used_q - 1'b1) flush_end = 1'b1;
            else                        idx_d     = idx_q + 1'b1;
          end
        end
        if (flush_end) begin
          state_d         = ST_COLLECT;
          idx_d           = '0;
          word_d          = '0;
          used_d          = '0;
          table_full_d    = 1'b0;
          // A flush that arrives on the closing cycle re-arms the next flush.
          flush_pending_d = flush;
        end
      end

      default: begin
        state_d = ST_COLLECT;
        idx_d   = '0;
      end
    endcase

    // Drop in_ready before a pending flush starts on a pair boundary.
    // Then no word can arrive on the cycle the FSM leaves COLLECT.
    in_ready_d = (state_d == ST_COLLECT) && !(flush_pending_d && beat_nxt == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_COLLECT;
      idx_q           <= '0;
      used_q          <= '0;
      word_q          <= '0;
      flush_pending_q <= 1'b0;
      table_full_q    <= 1'b0;
      in_ready_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      used_q          <= used_d;
      word_q          <= word_d;
      flush_pending_q <= flush_pending_d;
      table_full_q    <= table_full_d;
      in_ready_q      <= in_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) begin
      key_q[used_q] <= in_key;
      cnt_q[used_q] <= in_cnt;
    end else if (add_en) begin
      cnt_q[idx_q] <= add_count(cnt_q[idx_q], in_cnt);
    end
  end

  // The output word mirrors the input pair layout: count first, key high word last.
  assign entry_pair     = {key_q[idx_q], cnt_q[idx_q]};
  assign data_out_ready = emit;
  assign data_out       = emit ? entry_pair[word_q*WORD_W +: WORD_W] : '0;
  assign in_ready       = in_ready_q;
  assign table_full     = table_full_q;

endmodule

// File: tb/tb_reducer_noc.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_reducer_noc
// Directed bench for reducer_noc. It drives inputs just after the rising edge
// and samples registered outputs just after the edge. Flush output is sampled
// on the falling edge. Expected words are built from the keys and counts the
// bench sends.
// -----------------------------------------------------------------------------
module tb_reducer_noc;

  localparam int DEPTH = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data_in = '0;
  logic        data_in_ready = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        fifo_in_ready = 1'b1;
  logic [31:0] data_out;
  logic        data_out_ready;
  logic        table_full;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;

  logic [31:0] got[$];
  logic [31:0] expq[$];
  int          zero_bad, follow_bad, first_v, last_v;
  bit          timed_out;
  bit          rdy_hist [256];
  bit          fifo_hist[256];

  reducer_noc #(.DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_in_ready  (data_in_ready),
    .in_ready       (in_ready),
    .flush          (flush),
    .fifo_in_ready  (fifo_in_ready),
    .data_out       (data_out),
    .data_out_ready (data_out_ready),
    .table_full     (table_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 100 && in_ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    check("in_ready_before_beat", in_ready, 1'b1);
    data_in       = w;
    data_in_ready = 1'b1;
    @(posedge clk); #1;
    data_in_ready = 1'b0;
    data_in       = '0;
  endtask

  task automatic send_pair(input logic [95:0] key, input logic [31:0] cnt);
    send_word(cnt);
    send_word(key[31:0]);
    send_word(key[63:32]);
    send_word(key[95:64]);
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 100 && in_ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    check(tag, in_ready, 1'b1);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic add_exp(input logic [95:0] key, input logic [31:0] cnt);
    expq.push_back(cnt);
    expq.push_back(key[31:0]);
    expq.push_back(key[63:32]);
    expq.push_back(key[95:64]);
  endtask

  // Optionally pulse flush. Then collect every valid output word until
  // in_ready returns at the end of the flush.
  task automatic run_flush(input bit do_pulse, input bit toggle);
    got.delete();
    zero_bad   = 0;
    follow_bad = 0;
    first_v    = -1;
    last_v     = -1;
    timed_out  = 1'b1;
    if (do_pulse) pulse_flush();
    for (int c = 0; c < 256; c++) begin
      fifo_in_ready = toggle ? (c % 2 == 0) : 1'b1;
      @(negedge clk);
      rdy_hist[c]  = data_out_ready;
      fifo_hist[c] = fifo_in_ready;
      if (data_out_ready === 1'b1) begin
        got.push_back(data_out);
        if (first_v < 0) first_v = c;
        last_v = c;
      end else if (data_out !== '0) begin
        zero_bad++;
      end
      @(posedge clk); #1;
      if (in_ready === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
    end
    fifo_in_ready = 1'b1;
    if (first_v >= 0)
      for (int c = first_v; c <= last_v; c++)
        if (rdy_hist[c] !== fifo_hist[c]) follow_bad++;
    check("flush_done", timed_out, 1'b0);
    check("data_out_zero_when_idle", zero_bad, 0);
    check("ready_follows_fifo", follow_bad, 0);
  endtask

  task automatic compare_got(input string tag);
    check({tag, "_word_count"}, got.size(), expq.size());
    for (int i = 0; i < got.size() && i < expq.size(); i++)
      check($sformatf("%s_w%0d", tag, i), got[i], expq[i]);
    expq.delete();
  endtask

  logic [95:0] key_a, key_b, key_d, key_f, key_g, key_h, key_j, key_k, key_n;
  bit          seen;

  initial begin
    key_a = 96'hA1A1A1A1_A2A2A2A2_A3A3A3A3;
    key_b = 96'hB1B1B1B1_B2B2B2B2_B3B3B3B3;
    key_d = 96'hD0000001_D0000002_D0000003;
    key_f = 96'hF0F0F0F0_0F0F0F0F_12345678;
    key_g = 96'h9ABCDEF0_11111111_22222222;
    key_h = 96'h33333333_44444444_55555555;
    key_j = 96'h66666666_77777777_88888888;
    key_k = 96'h99999999_AAAAAAAA_BBBBBBBB;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_data_out_ready", data_out_ready, 1'b0);
    check("rst_data_out", data_out, 32'h0);
    check("rst_table_full", table_full, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1'b1);

    // Reduction: A+1, B+2, A+3 gives A=4 and B=2, eight words back to back.
    send_pair(key_a, 32'd1);
    send_pair(key_b, 32'd2);
    send_pair(key_a, 32'd3);
    run_flush(1'b1, 1'b0);
    add_exp(key_a, 32'd4);
    add_exp(key_b, 32'd2);
    compare_got("reduce_ab");
    check("reduce_ab_contiguous", last_v - first_v + 1, 8);
    check("reduce_ab_table_full", table_full, 1'b0);

    // Overflow: DEPTH+1 distinct keys. The last key is dropped.
    for (int i = 0; i <= DEPTH; i++) begin
      key_n = {32'(32'hC0DE_0000 + i), 32'(32'h5555_0000 + i), 32'(32'h1234_0000 + i)};
      send_pair(key_n, 32'(i + 1));
      if (i < DEPTH) add_exp(key_n, 32'(i + 1));
      if (i == DEPTH - 1) begin
        wait_ready("fill_search_done");
        check("fill_not_full_yet", table_full, 1'b0);
      end
    end
    wait_ready("overflow_search_done");
    check("overflow_table_full", table_full, 1'b1);
    run_flush(1'b1, 1'b0);
    compare_got("overflow");
    check("overflow_table_full_cleared", table_full, 1'b0);

    // Flush after beat 2 of a pair. The pair is reduced before any output.
    send_pair(key_d, 32'd5);
    send_word(32'd7);
    send_word(key_d[31:0]);
    pulse_flush();
    send_word(key_d[63:32]);
    send_word(key_d[95:64]);
    run_flush(1'b0, 1'b0);
    add_exp(key_d, 32'd12);
    compare_got("mid_pair_flush");

    // Backpressure: fifo_in_ready alternates during the flush.
    send_pair(key_f, 32'd1);
    send_pair(key_g, 32'd2);
    run_flush(1'b1, 1'b1);
    add_exp(key_f, 32'd1);
    add_exp(key_g, 32'd2);
    compare_got("toggle");
    check("toggle_span", last_v - first_v + 1, 15);

    // Count overflow on the same key.
    send_pair(key_h, 32'hFFFF_FFFF);
    send_pair(key_h, 32'd2);
    run_flush(1'b1, 1'b0);
`ifdef REDUCER_SAT_ADD_EN
    add_exp(key_h, 32'hFFFF_FFFF);
`else
    add_exp(key_h, 32'h0000_0001);
`endif
    compare_got("count_overflow");

    // Reset in the middle of a flush.
    send_pair(key_j, 32'd1);
    send_pair(key_k, 32'd2);
    pulse_flush();
    fifo_in_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (data_out_ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("mid_flush_started", seen, 1'b1);
    #1 rst = 1'b0;
    #1;
    check("mid_flush_rst_data_out_ready", data_out_ready, 1'b0);
    check("mid_flush_rst_data_out", data_out, 32'h0);
    check("mid_flush_rst_in_ready", in_ready, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("after_rst_in_ready", in_ready, 1'b1);
    check("after_rst_data_out_ready", data_out_ready, 1'b0);
    run_flush(1'b1, 1'b0);
    compare_got("empty_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
